// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM encoding, WB control
// bit positions and default stage parameters.
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int unsigned WB_REGWRITE     = 1;
  localparam int unsigned WB_MEMTOREG     = 0;
  localparam int unsigned MEM_LAT_DEFAULT = 2;
  localparam int unsigned DEPTH_W_DEFAULT = 8;

endpackage

// File: rtl/data_mem_array.sv
// Word-addressed data memory: synchronous write port, combinational read port.
// Contents are not reset.
module data_mem_array #(
  parameter int unsigned DEPTH_W = 8
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [DEPTH_W-1:0] widx_i,
  input  logic [31:0]        wdata_i,
  input  logic [DEPTH_W-1:0] ridx_i,
  output logic [31:0]        rdata_o
);

  logic [31:0] mem_q [2**DEPTH_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage of the 5-stage pipeline: branch resolution, multi-cycle data-memory access
// with pipeline stall, and the MEM/WB register.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT,
  parameter int unsigned DEPTH_W = DEPTH_W_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wb_in,
  input  logic        branch_in,
  input  logic        zero_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [31:0] branch_target_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  dest_reg_in,
  output logic        pc_src,
  output logic [31:0] branch_target_out,
  output logic        stall,
  output logic [1:0]  wb_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  dest_reg_out,
  output logic        misalign_out
);

  localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        wb_q, wb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       alu_q, alu_d;
  logic [4:0]        dest_q, dest_d;
  logic              mis_q, mis_d;

  logic              mem_op, req, misaligned, complete, mem_we;
  logic [DEPTH_W-1:0] word_idx;
  logic [31:0]       mem_rdata;

  assign pc_src            = branch_in & zero_in;
  assign branch_target_out = branch_target_in;

  assign mem_op     = mem_read_in | mem_write_in;
  assign req        = mem_op & (alu_result_in[1:0] == 2'b00);
  assign misaligned = mem_op & (alu_result_in[1:0] != 2'b00);
  assign word_idx   = alu_result_in[DEPTH_W+1:2];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req && (MEM_LAT != 0)) begin
          stall   = 1'b1;
          state_d = BUSY;
          cnt_d   = CntW'(MEM_LAT - 1);
        end else begin
          complete = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          stall = 1'b1;
          cnt_d = cnt_q - CntW'(1);
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A store commits only on its completing edge; reset drops it.
  assign mem_we = complete & req & mem_write_in & ~rst;

  always_comb begin
    wb_d    = 2'b00;
    rdata_d = 32'h0;
    alu_d   = 32'h0;
    dest_d  = 5'd0;
    mis_d   = 1'b0;
    if (complete) begin
      wb_d    = misaligned ? 2'b00 : wb_in;
      rdata_d = (req && mem_read_in && !mem_write_in) ? mem_rdata : 32'h0;
      alu_d   = alu_result_in;
      dest_d  = dest_reg_in;
      mis_d   = misaligned;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wb_q    <= 2'b00;
      rdata_q <= 32'h0;
      alu_q   <= 32'h0;
      dest_q  <= 5'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      dest_q  <= dest_d;
      mis_q   <= mis_d;
    end
  end

  assign wb_out         = wb_q;
  assign read_data_out  = rdata_q;
  assign alu_result_out = alu_q;
  assign dest_reg_out   = dest_q;
  assign misalign_out   = mis_q;

  data_mem_array #(
    .DEPTH_W(DEPTH_W)
  ) u_dmem (
    .clk_i  (clk),
    .we_i   (mem_we),
    .widx_i (word_idx),
    .wdata_i(store_data_in),
    .ridx_i (word_idx),
    .rdata_o(mem_rdata)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios plus random ops against an
// instruction-level memory model.
module tb_mem_stage_ctrl;

  localparam int unsigned MEM_LAT = 2;
  localparam int unsigned DEPTH_W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wb_in;
  logic        branch_in, zero_in, mem_read_in, mem_write_in;
  logic [31:0] branch_target_in, alu_result_in, store_data_in;
  logic [4:0]  dest_reg_in;
  logic        pc_src, stall, misalign_out;
  logic [31:0] branch_target_out, read_data_out, alu_result_out;
  logic [1:0]  wb_out;
  logic [4:0]  dest_reg_out;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] model_mem [2**DEPTH_W];

  always #5 clk = ~clk;

  mem_stage_ctrl #(
    .MEM_LAT(MEM_LAT),
    .DEPTH_W(DEPTH_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .wb_in            (wb_in),
    .branch_in        (branch_in),
    .zero_in          (zero_in),
    .mem_read_in      (mem_read_in),
    .mem_write_in     (mem_write_in),
    .branch_target_in (branch_target_in),
    .alu_result_in    (alu_result_in),
    .store_data_in    (store_data_in),
    .dest_reg_in      (dest_reg_in),
    .pc_src           (pc_src),
    .branch_target_out(branch_target_out),
    .stall            (stall),
    .wb_out           (wb_out),
    .read_data_out    (read_data_out),
    .alu_result_out   (alu_result_out),
    .dest_reg_out     (dest_reg_out),
    .misalign_out     (misalign_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    wb_in = 2'b00; branch_in = 1'b0; zero_in = 1'b0;
    mem_read_in = 1'b0; mem_write_in = 1'b0;
    branch_target_in = 32'h0; alu_result_in = 32'h0;
    store_data_in = 32'h0; dest_reg_in = 5'd0;
  endtask

  task automatic check_regs_zero(input string tag);
    check({tag, "_wb"}, {30'h0, wb_out}, 32'h0);
    check({tag, "_rd"}, read_data_out, 32'h0);
    check({tag, "_alu"}, alu_result_out, 32'h0);
    check({tag, "_dest"}, {27'h0, dest_reg_out}, 32'h0);
    check({tag, "_mis"}, {31'h0, misalign_out}, 32'h0);
  endtask

  // One instruction through MEM; called just after a clock edge.
  task automatic run_op(input logic [1:0] wb, input logic br, input logic z,
                        input logic rd, input logic wr, input logic [31:0] tgt,
                        input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] dest);
    logic        mem_op, alig;
    int unsigned exp_st, n, idx;
    logic [31:0] exp_rd;
    wb_in = wb; branch_in = br; zero_in = z; mem_read_in = rd; mem_write_in = wr;
    branch_target_in = tgt; alu_result_in = addr; store_data_in = sd; dest_reg_in = dest;
    mem_op = rd | wr;
    alig   = (addr[1:0] == 2'b00);
    idx    = 32'(addr[DEPTH_W+1:2]);
    exp_st = (mem_op && alig) ? MEM_LAT : 0;
    exp_rd = (mem_op && alig && rd && !wr) ? model_mem[idx] : 32'h0;
    #1;
    check("pc_src", {31'h0, pc_src}, {31'h0, br & z});
    check("br_target", branch_target_out, tgt);
    check("stall_now", {31'h0, stall}, (exp_st > 0) ? 32'h1 : 32'h0);
    n = 0;
    while (stall === 1'b1 && n <= MEM_LAT + 4) begin
      @(posedge clk); #1;
      n++;
      check("bubble_wb", {30'h0, wb_out}, 32'h0);
    end
    check("stall_cycles", n, exp_st);
    @(posedge clk); #1;
    check("wb_out", {30'h0, wb_out}, (mem_op && !alig) ? 32'h0 : {30'h0, wb});
    check("read_data", read_data_out, exp_rd);
    check("alu_out", alu_result_out, addr);
    check("dest_out", {27'h0, dest_reg_out}, {27'h0, dest});
    check("misalign", {31'h0, misalign_out}, {31'h0, mem_op & ~alig});
    if (mem_op && alig && wr) model_mem[idx] = sd;
  endtask

  initial begin
    logic [31:0] a, d;
    int unsigned kind;

    // Reset and first non-memory op.
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_regs_zero("reset");
    check("reset_stall", {31'h0, stall}, 32'h0);
    rst = 1'b0;
    run_op(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1234, 32'h0, 5'd5);

    // Give the first 16 words known contents.
    for (int i = 0; i < 16; i++) begin
      run_op(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'(i * 4), $urandom, 5'd0);
    end

    // Store then load.
    run_op(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h10, 32'hDEADBEEF, 5'd0);
    run_op(2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h10, 32'h0, 5'd9);

    // Branch taken / not taken.
    run_op(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 5'd0);
    run_op(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 5'd0);

    // Misaligned store is suppressed.
    run_op(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h13, 32'h12345678, 5'd3);
    run_op(2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h10, 32'h0, 5'd4);

    // Address wrap.
    run_op(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h400, 32'hA5A5A5A5, 5'd0);
    run_op(2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h000, 32'h0, 5'd6);

    // Both read and write: write wins, no load data.
    run_op(2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h24, 32'h0BADF00D, 5'd7);
    run_op(2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h24, 32'h0, 5'd7);

    // Reset during the cycle the store raises stall.
    run_op(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hCAFE, 32'h0, 5'd11);
    mem_write_in = 1'b1; alu_result_in = 32'h20; store_data_in = 32'h1;
    #1;
    check("rstA_stall_pre", {31'h0, stall}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    #1;
    check("rstA_stall_post", {31'h0, stall}, 32'h0);
    check_regs_zero("rstA");
    run_op(2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h20, 32'h0, 5'd1);

    // Reset while the store is in BUSY.
    mem_write_in = 1'b1; alu_result_in = 32'h20; store_data_in = 32'h2;
    @(posedge clk); #1;
    check("rstB_stall_busy", {31'h0, stall}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    #1;
    check("rstB_stall_post", {31'h0, stall}, 32'h0);
    run_op(2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h20, 32'h0, 5'd2);

    // Random ops over the known words, upper address bits random to exercise wrap.
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 4);
      a = $urandom;
      a[DEPTH_W+1:2] = 8'($urandom_range(0, 15));
      a[1:0] = (kind == 4) ? 2'($urandom_range(1, 3)) : 2'b00;
      d = $urandom;
      run_op(2'($urandom), 1'($urandom), 1'($urandom),
             (kind == 1) || (kind == 3) || ((kind == 4) && d[0]),
             (kind == 2) || (kind == 3) || ((kind == 4) && !d[0]),
             $urandom, a, d, 5'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
